// File: rtl/debounce_edge_counter.sv
// debounce_edge_counter: resynchronise, debounce and edge-detect din; count debounced rising events
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   din        raw level from upstream flip-flop Q
//   clr        synchronous clear of count and overflow
//   db_out     debounced level
//   rise_pulse one-cycle pulse after a debounced 0->1 transition
//   fall_pulse one-cycle pulse after a debounced 1->0 transition
//   count      debounced rising events, modulo 2^CNT_W
//   overflow   sticky, set when count wraps
module debounce_edge_counter #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             clr,
   output logic             db_out,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);
   typedef enum logic [1:0] {S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK} state_t;
   localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);
   state_t state, state_n;
   logic sync0, sync1, rise_ev, fall_ev;
   logic [7:0] stable_cnt, stable_cnt_n;
   always_comb begin
      state_n = state;
      stable_cnt_n = stable_cnt;
      rise_ev = 1'b0;
      fall_ev = 1'b0;
      case (state)
         S_LOW:
            if (sync1) begin
               if (STABLE_CYCLES == 1) begin
                  state_n = S_HIGH;
                  rise_ev = 1'b1;
               end else begin
                  state_n = S_RISE_CHK;
                  stable_cnt_n = 8'd1;
               end
            end
         S_RISE_CHK:
            if (!sync1) begin
               state_n = S_LOW;
               stable_cnt_n = 8'd0;
            end else if (stable_cnt == LAST) begin
               state_n = S_HIGH;
               stable_cnt_n = 8'd0;
               rise_ev = 1'b1;
            end else stable_cnt_n = stable_cnt + 8'd1;
         S_HIGH:
            if (!sync1) begin
               if (STABLE_CYCLES == 1) begin
                  state_n = S_LOW;
                  fall_ev = 1'b1;
               end else begin
                  state_n = S_FALL_CHK;
                  stable_cnt_n = 8'd1;
               end
            end
         S_FALL_CHK:
            if (sync1) begin
               state_n = S_HIGH;
               stable_cnt_n = 8'd0;
            end else if (stable_cnt == LAST) begin
               state_n = S_LOW;
               stable_cnt_n = 8'd0;
               fall_ev = 1'b1;
            end else stable_cnt_n = stable_cnt + 8'd1;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         sync0 <= 1'b0;
         sync1 <= 1'b0;
         state <= S_LOW;
         stable_cnt <= 8'd0;
         db_out <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         count <= '0;
         overflow <= 1'b0;
      end else begin
         sync0 <= din;
         sync1 <= sync0;
         state <= state_n;
         stable_cnt <= stable_cnt_n;
         db_out <= (state_n == S_HIGH) || (state_n == S_FALL_CHK);
         rise_pulse <= rise_ev;
         fall_pulse <= fall_ev;
         // a rise coinciding with clr is kept as the first event after the clear
         if (clr) begin
            count <= {{(CNT_W-1){1'b0}}, rise_ev};
            overflow <= 1'b0;
         end else if (rise_ev) begin
            count <= count + 1'b1;
            if (&count) overflow <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_debounce_edge_counter.sv
// tb_debounce_edge_counter: random and directed checks of two debounce_edge_counter instances against a window model
module tb_debounce_edge_counter;
   logic clk = 1'b0, reset = 1'b1, din = 1'b0, clr = 1'b0;
   logic db [2], rp [2], fp [2], ov [2];
   logic [3:0] cnt [2];
   int n_pass = 0, n_tot = 0;
   bit ms0 [2], ms1 [2], mdb [2], mrp [2], mfp [2], mov [2];
   int mcnt [2], hlen [2];
   logic [255:0] hist [2];
   always #5 clk = ~clk;
   debounce_edge_counter #(.STABLE_CYCLES(4), .CNT_W(4)) u0 (
      .clk(clk), .reset(reset), .din(din), .clr(clr), .db_out(db[0]), .rise_pulse(rp[0]),
      .fall_pulse(fp[0]), .count(cnt[0]), .overflow(ov[0]));
   debounce_edge_counter #(.STABLE_CYCLES(1), .CNT_W(4)) u1 (
      .clk(clk), .reset(reset), .din(din), .clr(clr), .db_out(db[1]), .rise_pulse(rp[1]),
      .fall_pulse(fp[1]), .count(cnt[1]), .overflow(ov[1]));
   task automatic chk(string tag, int got, int exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
   endtask
   // db flips once the last S synchronised samples all differ from it
   task automatic medge(int i);
      int s;
      bit samp, flip, rise, fall;
      s = (i == 0) ? 4 : 1;
      if (reset) begin
         ms0[i] = 0; ms1[i] = 0; hist[i] = '0; hlen[i] = 0; mdb[i] = 0;
         mrp[i] = 0; mfp[i] = 0; mcnt[i] = 0; mov[i] = 0;
         return;
      end
      samp = ms1[i];
      ms1[i] = ms0[i];
      ms0[i] = din;
      hist[i] = {hist[i][254:0], samp};
      hlen[i]++;
      flip = hlen[i] >= s;
      for (int j = 0; j < s; j++) if (hist[i][j] == mdb[i]) flip = 0;
      rise = flip && !mdb[i];
      fall = flip && mdb[i];
      if (flip) begin
         mdb[i] = !mdb[i];
         hlen[i] = 0;
      end
      mrp[i] = rise;
      mfp[i] = fall;
      if (clr) begin
         mcnt[i] = rise ? 1 : 0;
         mov[i] = 0;
      end else if (rise) begin
         mcnt[i] = (mcnt[i] + 1) % 16;
         if (mcnt[i] == 0) mov[i] = 1;
      end
   endtask
   task automatic step();
      @(posedge clk);
      medge(0);
      medge(1);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("db_out%0d", i), int'(db[i]), int'(mdb[i]));
         chk($sformatf("rise%0d", i), int'(rp[i]), int'(mrp[i]));
         chk($sformatf("fall%0d", i), int'(fp[i]), int'(mfp[i]));
         chk($sformatf("count%0d", i), int'(cnt[i]), mcnt[i]);
         chk($sformatf("overflow%0d", i), int'(ov[i]), int'(mov[i]));
         if (rp[i] === 1'b1 && fp[i] === 1'b1) chk($sformatf("both_pulses%0d", i), 1, 0);
      end
   endtask
   task automatic hold(bit d, int n);
      din = d;
      repeat (n) step();
   endtask
   initial begin
      repeat (2) step();
      reset = 0;
      hold(0, 3);
      din = 1;
      repeat (5) step();
      chk("t1_db_before", int'(db[0]), 0);
      step();
      chk("t1_db_k5", int'(db[0]), 1);
      chk("t1_rise_k5", int'(rp[0]), 1);
      hold(1, 2);
      chk("t1_cnt", int'(cnt[0]), 1);
      hold(0, 8);
      chk("t3_cnt_kept", int'(cnt[0]), 1);
      hold(1, 3);
      hold(0, 8);
      chk("t2_glitch_cnt", int'(cnt[0]), 1);
      hold(1, 6);
      hold(1, 4);
      hold(0, 8);
      chk("t2_cnt", int'(cnt[0]), 2);
      clr = 1;
      step();
      clr = 0;
      repeat (17) begin
         hold(1, 7);
         hold(0, 7);
      end
      chk("t4_cnt_wrap", int'(cnt[0]), 1);
      chk("t4_ovf", int'(ov[0]), 1);
      clr = 1;
      step();
      clr = 0;
      chk("t4_clr_cnt", int'(cnt[0]), 0);
      chk("t4_clr_ovf", int'(ov[0]), 0);
      din = 1;
      repeat (5) step();
      clr = 1;
      step();
      clr = 0;
      chk("t5_cnt", int'(cnt[0]), 1);
      chk("t5_ovf", int'(ov[0]), 0);
      hold(1, 3);
      hold(0, 8);
      hold(1, 4);
      reset = 1;
      step();
      reset = 0;
      chk("t6_db_rst", int'(db[0]), 0);
      hold(1, 8);
      chk("t6_cnt", int'(cnt[0]), 1);
      hold(0, 8);
      repeat (300) begin
         din = 1'($urandom_range(0, 1));
         clr = ($urandom_range(0, 15) == 0);
         reset = ($urandom_range(0, 63) == 0);
         repeat ($urandom_range(1, 7)) step();
         clr = 0;
         reset = 0;
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/debounce_edge_counter.md
Name: debounce_edge_counter

Overview:
- Consumes the registered single-bit output of the upstream D flip-flop stage (its Q) on `din`.
- Resynchronises it, debounces it over a programmable number of stable cycles, and emits one-cycle rise/fall event pulses.
- Counts rising events with a wrapping counter and a sticky overflow flag.
- Sits directly downstream of the flip-flop stage and feeds status/display logic.

Parameters:
- STABLE_CYCLES, 4: consecutive cycles the synchronised input must differ from `db_out` before `db_out` flips. Legal range 1..255.
- CNT_W, 8: width of the event counter `count`.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- din  input  1  raw level from upstream flip-flop Q.
- clr  input  1  synchronous clear of `count` and `overflow`.
- db_out  output  1  debounced level.
- rise_pulse  output  1  one-cycle pulse on a debounced 0->1 transition.
- fall_pulse  output  1  one-cycle pulse on a debounced 1->0 transition.
- count  output  CNT_W  number of debounced rising events, modulo 2^CNT_W.
- overflow  output  1  sticky; set when `count` wraps.

Behaviour:
- All state updates on rising `clk` only. No asynchronous paths.
- Reset (synchronous, active-high) has the highest priority:
  - sync0, sync1, stable_cnt, db_out, rise_pulse, fall_pulse, count and overflow all become 0.
  - FSM enters S_LOW.
  - Reset asserted mid-debounce aborts the window; nothing partial is retained.
- Synchroniser: sync0 <= din; sync1 <= sync0. Only sync1 feeds the FSM.
- stable_cnt width is 8 bits.
- FSM states and transitions:
  - S_LOW (db_out=0): sync1=1 -> S_RISE_CHK with stable_cnt=1. If STABLE_CYCLES=1, go straight to S_HIGH instead and fire the rise event.
  - S_RISE_CHK (db_out=0):
    - sync1=0 -> S_LOW, stable_cnt=0 (glitch rejected, no pulse).
    - sync1=1 and stable_cnt==STABLE_CYCLES-1 -> S_HIGH, stable_cnt=0, rise event.
    - Otherwise stable_cnt++.
  - S_HIGH (db_out=1): sync1=0 -> S_FALL_CHK with stable_cnt=1. If STABLE_CYCLES=1, go straight to S_LOW and fire the fall event.
  - S_FALL_CHK: mirror of S_RISE_CHK with polarities swapped; terminates in S_LOW with a fall event.
- db_out is a register: 1 in S_HIGH/S_FALL_CHK, 0 in S_LOW/S_RISE_CHK.
- Latency: `din` stable at a new level from before edge k -> sync1 changes after edge k+1 -> `db_out` changes after edge k+1+STABLE_CYCLES. With the default of 4, that is edge k+5.
- Pulses:
  - rise_pulse and fall_pulse are registered, high for exactly the one cycle following the edge on which `db_out` changes.
  - They are never both high.
- Counter update on each edge, in priority order:
  1. reset.
  2. clr with a coincident rise event: count <= 1, overflow <= 0 (the event is not lost).
  3. clr alone: count <= 0, overflow <= 0.
  4. rise event: count <= count+1 (wrap 2^CNT_W-1 -> 0); on wrap, overflow <= 1.
  5. Otherwise hold.
- Fall events never change `count`.
- `din` held high through reset release: counts as a fresh rise after the normal latency; `count` becomes 1.

Test Plan:
1. Reset then clean step: reset for 2 cycles with din=0; set din=1 before edge k and hold -> db_out=1 and rise_pulse=1 for one cycle after edge k+5, count=1, fall_pulse stays 0.
2. Glitch rejection: from db_out=0, din=1 for 3 cycles then 0 -> db_out, rise_pulse and count remain 0. Then din=1 for 6 cycles -> exactly one rise, count=1.
3. Fall path: from db_out=1, din=0 held -> fall_pulse one cycle after edge k+5, db_out=0, count unchanged.
4. Wrap/overflow (CNT_W=4): drive 16 clean rise/fall pairs -> count goes 15 -> 0 and overflow=1. 17th rise -> count=1, overflow still 1. Pulse clr with no coincident event -> count=0, overflow=0.
5. clr coincident with rise event edge -> count=1, overflow=0.
6. Reset mid-window: din=1, assert reset on the edge where stable_cnt=2 -> all outputs 0 next cycle. Release with din still 1 -> rise after the full latency from release, count=1. Repeat with STABLE_CYCLES=1 -> db_out rises after edge k+2.
